iob_cache_front_end_q: RTL and testbench



---
 rtl/iob_cache_front_end_q_pkg.sv | 32 +++
 rtl/iob_cache_req_fifo.sv | 67 ++++++
 rtl/iob_cache_front_end_q.sv | 169 ++++++++++++++++
 tb/tb_iob_cache_front_end_q.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_cache_front_end_q_pkg.sv
// rtl/iob_cache_front_end_q_pkg.sv - shared widths and helpers for the queued cache front end
// Purpose: holds the control-address width and the byte/word width derivations
//          used by iob_cache_front_end_q and iob_cache_req_fifo.
// Ports: none (package).
package iob_cache_front_end_q_pkg;

  // Word-address bits forwarded to the cache-control block.
  localparam int CTRL_ADDR_W = 4;

  function automatic int fe_nbytes(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int fe_byte_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // Index width that never collapses to zero bits for a single entry.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/iob_cache_req_fifo.sv
// rtl/iob_cache_req_fifo.sv - request FIFO with registered storage and occupancy level
// Purpose: DEPTH-entry FIFO holding packed CPU requests; head is read combinationally.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   push, push_data   write an entry (ignored when full)
//   pop               drop the head entry (ignored when empty)
//   head_data         current head entry
//   full, empty       occupancy flags
//   level             number of stored entries
module iob_cache_req_fifo
  import iob_cache_front_end_q_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [LVL_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign full      = (cnt == LVL_W'(DEPTH));
  assign empty     = (cnt == '0);
  assign level     = cnt;
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign head_data = mem[rd_ptr];

  // Storage needs no reset: the head is only observed while non-empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/iob_cache_front_end_q.sv
// rtl/iob_cache_front_end_q.sv - queued cache front end with read watchpoints
// Purpose: queues CPU requests, presents the head to cache-memory or cache-control,
//          returns in-order responses and counts watchpoint hits on completed reads.
// Ports:
//   clk, reset                          clock, asynchronous active-high reset
//   req_valid/addr/wdata/wstrb, req_ready   CPU request (wstrb==0 is a read)
//   rsp_valid, rsp_rdata                completion pulse and read data
//   data_valid/addr/wdata/wstrb, data_rdata, data_ready   cache-memory back end
//   ctrl_valid/addr, ctrl_rdata, ctrl_ready               cache-control back end
//   watch_we/sel/en_in/addr_in/data_in  watchpoint programming
//   watch_hit, watch_cnt                registered hit pulses, saturating hit count
module iob_cache_front_end_q
  import iob_cache_front_end_q_pkg::*;
#(
  parameter int FE_ADDR_W  = 32,
  parameter int FE_DATA_W  = 32,
  parameter int CTRL_CACHE = 0,
  parameter int DEPTH      = 2,
  parameter int N_WATCH    = 4,
  localparam int FE_NBYTES = fe_nbytes(FE_DATA_W),
  localparam int FE_BYTE_W = fe_byte_w(FE_DATA_W),
  localparam int WADDR_W   = FE_ADDR_W - FE_BYTE_W,
  localparam int SEL_W     = idx_w(N_WATCH)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             req_valid,
  input  logic [CTRL_CACHE+FE_ADDR_W-1:0]  req_addr,
  input  logic [FE_DATA_W-1:0]             req_wdata,
  input  logic [FE_NBYTES-1:0]             req_wstrb,
  output logic                             req_ready,
  output logic                             rsp_valid,
  output logic [FE_DATA_W-1:0]             rsp_rdata,
  output logic                             data_valid,
  output logic [WADDR_W-1:0]               data_addr,
  output logic [FE_DATA_W-1:0]             data_wdata,
  output logic [FE_NBYTES-1:0]             data_wstrb,
  input  logic [FE_DATA_W-1:0]             data_rdata,
  input  logic                             data_ready,
  output logic                             ctrl_valid,
  output logic [CTRL_ADDR_W-1:0]           ctrl_addr,
  input  logic [FE_DATA_W-1:0]             ctrl_rdata,
  input  logic                             ctrl_ready,
  input  logic                             watch_we,
  input  logic [SEL_W-1:0]                 watch_sel,
  input  logic                             watch_en_in,
  input  logic [WADDR_W-1:0]               watch_addr_in,
  input  logic [FE_DATA_W-1:0]             watch_data_in,
  output logic [N_WATCH-1:0]               watch_hit,
  output logic [7:0]                       watch_cnt
);

  localparam int ENT_W = 1 + WADDR_W + FE_DATA_W + FE_NBYTES;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic                 req_sel;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic [LVL_W-1:0]     fifo_level;
  logic [ENT_W-1:0]     push_data;
  logic [ENT_W-1:0]     head_data;
  logic                 head_valid;
  logic                 head_sel;
  logic [WADDR_W-1:0]   head_addr;
  logic [FE_DATA_W-1:0] head_wdata;
  logic [FE_NBYTES-1:0] head_wstrb;
  logic                 unused_sink;

  generate
    if (CTRL_CACHE != 0) begin : g_sel
      assign req_sel = req_addr[FE_ADDR_W];
    end else begin : g_nosel
      assign req_sel = 1'b0;
    end
  endgenerate

  // Full blocks acceptance outright, even if the head pops this cycle.
  assign req_ready = ~full;
  assign push      = req_valid & ~full;
  assign push_data = {req_sel, req_addr[FE_ADDR_W-1:FE_BYTE_W], req_wdata, req_wstrb};

  iob_cache_req_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_req_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head_data),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level)
  );

  assign {head_sel, head_addr, head_wdata, head_wstrb} = head_data;
  assign head_valid = ~empty;

  assign data_valid = head_valid & ~head_sel;
  assign ctrl_valid = head_valid & head_sel;
  assign pop        = (data_valid & data_ready) | (ctrl_valid & ctrl_ready);

  // Head fields read as zero while the queue is empty.
  assign data_addr  = head_valid ? head_addr  : '0;
  assign data_wdata = head_valid ? head_wdata : '0;
  assign data_wstrb = head_valid ? head_wstrb : '0;

  generate
    if (CTRL_CACHE != 0) begin : g_ctrl_addr
      assign ctrl_addr = head_valid ? head_addr[CTRL_ADDR_W-1:0] : '0;
    end else begin : g_no_ctrl_addr
      assign ctrl_addr = '0;
    end
  endgenerate

  assign rsp_valid = pop;
  assign rsp_rdata = pop ? (head_sel ? ctrl_rdata : data_rdata) : '0;

  assign unused_sink = ^{req_addr[FE_BYTE_W-1:0], fifo_level};

  // Watchpoint table
  logic [N_WATCH-1:0]   wp_en;
  logic [WADDR_W-1:0]   wp_addr [N_WATCH];
  logic [FE_DATA_W-1:0] wp_data [N_WATCH];
  logic [N_WATCH-1:0]   hit_now;
  logic                 rd_pop;
  logic [8:0]           cnt_sum;

  // Only completed cache-memory reads are candidates.
  assign rd_pop = pop & ~head_sel & (head_wstrb == '0);

  always_comb begin
    hit_now = '0;
    for (int i = 0; i < N_WATCH; i++) begin
      hit_now[i] = rd_pop & wp_en[i] & (head_addr == wp_addr[i]) & (data_rdata == wp_data[i]);
    end
  end

  assign cnt_sum = {1'b0, watch_cnt} + {5'd0, popcount8(8'(hit_now))};

  // Table writes land on the edge, so a same-cycle compare sees the old entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_en <= '0;
      for (int i = 0; i < N_WATCH; i++) begin
        wp_addr[i] <= '0;
        wp_data[i] <= '0;
      end
    end else if (watch_we && (int'(watch_sel) < N_WATCH)) begin
      wp_en[watch_sel]   <= watch_en_in;
      wp_addr[watch_sel] <= watch_addr_in;
      wp_data[watch_sel] <= watch_data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      watch_hit <= '0;
      watch_cnt <= '0;
    end else begin
      watch_hit <= hit_now;
      watch_cnt <= cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
    end
  end

endmodule

// File: tb/tb_iob_cache_front_end_q.sv
// tb/tb_iob_cache_front_end_q.sv - randomized self-checking bench for iob_cache_front_end_q
module tb_iob_cache_front_end_q;

  localparam int DEPTH = 2;
  localparam int NW    = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [32:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        data_valid;
  logic [29:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic [31:0] data_rdata = '0;
  logic        data_ready = 1'b0;
  logic        ctrl_valid;
  logic [3:0]  ctrl_addr;
  logic [31:0] ctrl_rdata = '0;
  logic        ctrl_ready = 1'b0;
  logic        watch_we = 1'b0;
  logic [1:0]  watch_sel = '0;
  logic        watch_en_in = 1'b0;
  logic [29:0] watch_addr_in = '0;
  logic [31:0] watch_data_in = '0;
  logic [3:0]  watch_hit;
  logic [7:0]  watch_cnt;

  always #5 clk = ~clk;

  iob_cache_front_end_q #(
    .FE_ADDR_W  (32),
    .FE_DATA_W  (32),
    .CTRL_CACHE (1),
    .DEPTH      (DEPTH),
    .N_WATCH    (NW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_wstrb     (req_wstrb),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .data_valid    (data_valid),
    .data_addr     (data_addr),
    .data_wdata    (data_wdata),
    .data_wstrb    (data_wstrb),
    .data_rdata    (data_rdata),
    .data_ready    (data_ready),
    .ctrl_valid    (ctrl_valid),
    .ctrl_addr     (ctrl_addr),
    .ctrl_rdata    (ctrl_rdata),
    .ctrl_ready    (ctrl_ready),
    .watch_we      (watch_we),
    .watch_sel     (watch_sel),
    .watch_en_in   (watch_en_in),
    .watch_addr_in (watch_addr_in),
    .watch_data_in (watch_data_in),
    .watch_hit     (watch_hit),
    .watch_cnt     (watch_cnt)
  );

  // Reference model: a queue of pending requests plus the watchpoint table.
  typedef struct {
    bit        sel;
    bit [29:0] addr;
    bit [31:0] wdata;
    bit [3:0]  wstrb;
  } req_t;

  req_t        q[$];
  logic [31:0] rsp_log[$];
  bit          m_en[NW];
  bit [29:0]   m_addr[NW];
  bit [31:0]   m_data[NW];
  bit [3:0]    exp_hit;
  int          exp_cnt;
  bit          pushed;
  bit          rd_by_addr;
  logic [31:0] rd_fixed;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Back-end read data: either derived from the head address or a fixed value.
  task automatic drive_rd();
    if (rd_by_addr) data_rdata = (q.size() > 0) ? ({q[0].addr, 2'b00} + 32'hA0) : 32'h0;
    else            data_rdata = rd_fixed;
  endtask

  // Checks outputs mid-cycle, then advances the model across the next rising edge.
  task automatic cycle();
    req_t h;
    bit   has, exp_dv, exp_cv, exp_pop, is_full;
    bit [3:0] new_hit;
    @(negedge clk);
    has = (q.size() > 0);
    h   = has ? q[0] : '{sel: 1'b0, addr: 30'h0, wdata: 32'h0, wstrb: 4'h0};
    exp_dv  = has && !h.sel;
    exp_cv  = has && h.sel;
    exp_pop = (exp_dv && data_ready) || (exp_cv && ctrl_ready);
    is_full = (q.size() >= DEPTH);
    chk("req_ready", 64'(req_ready), 64'(!is_full));
    chk("data_valid", 64'(data_valid), 64'(exp_dv));
    chk("ctrl_valid", 64'(ctrl_valid), 64'(exp_cv));
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_pop));
    if (exp_dv) begin
      chk("data_addr", 64'(data_addr), 64'(h.addr));
      chk("data_wdata", 64'(data_wdata), 64'(h.wdata));
      chk("data_wstrb", 64'(data_wstrb), 64'(h.wstrb));
    end
    if (exp_cv) chk("ctrl_addr", 64'(ctrl_addr), 64'(h.addr[3:0]));
    if (exp_pop) begin
      chk("rsp_rdata", 64'(rsp_rdata), 64'(h.sel ? ctrl_rdata : data_rdata));
      rsp_log.push_back(rsp_rdata);
    end
    chk("watch_hit", 64'(watch_hit), 64'(exp_hit));
    chk("watch_cnt", 64'(watch_cnt), 64'(exp_cnt));

    new_hit = 4'b0;
    if (exp_pop && !h.sel && h.wstrb == 4'h0) begin
      for (int i = 0; i < NW; i++) begin
        if (m_en[i] && m_addr[i] == h.addr && m_data[i] == data_rdata) new_hit[i] = 1'b1;
      end
    end
    exp_hit = new_hit;
    exp_cnt = exp_cnt + $countones(new_hit);
    if (exp_cnt > 255) exp_cnt = 255;
    if (watch_we) begin
      m_en[watch_sel]   = watch_en_in;
      m_addr[watch_sel] = watch_addr_in;
      m_data[watch_sel] = watch_data_in;
    end
    if (exp_pop) void'(q.pop_front());
    if (req_valid && !is_full) begin
      q.push_back('{sel: req_addr[32], addr: req_addr[31:2], wdata: req_wdata, wstrb: req_wstrb});
      pushed = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 1'b0;
    watch_we = 1'b0;
    q.delete();
    for (int i = 0; i < NW; i++) begin
      m_en[i] = 1'b0; m_addr[i] = '0; m_data[i] = '0;
    end
    exp_hit = '0;
    exp_cnt = 0;
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_data_valid", 64'(data_valid), 64'd0);
    chk("rst_ctrl_valid", 64'(ctrl_valid), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_data_addr", 64'(data_addr), 64'd0);
    chk("rst_data_wdata", 64'(data_wdata), 64'd0);
    chk("rst_data_wstrb", 64'(data_wstrb), 64'd0);
    chk("rst_ctrl_addr", 64'(ctrl_addr), 64'd0);
    chk("rst_watch_hit", 64'(watch_hit), 64'd0);
    chk("rst_watch_cnt", 64'(watch_cnt), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_push(input int limit);
    int g = 0;
    pushed = 1'b0;
    while (!pushed && g < limit) begin drive_rd(); cycle(); g++; end
    if (!pushed) chk("push_timeout", 64'(g), 64'(limit + 1));
    req_valid = 1'b0;
  endtask

  task automatic drain(input int limit);
    int g = 0;
    while (q.size() > 0 && g < limit) begin drive_rd(); cycle(); g++; end
    if (q.size() > 0) chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  task automatic send(input logic [32:0] a, input logic [3:0] ws, input logic [31:0] rd);
    req_valid = 1'b1; req_addr = a; req_wstrb = ws; req_wdata = 32'($urandom);
    rd_by_addr = 1'b0; rd_fixed = rd; ctrl_rdata = rd;
    data_ready = 1'b1; ctrl_ready = 1'b1;
    wait_push(20);
    drain(20);
  endtask

  task automatic wprog(input logic [1:0] s, input logic en, input logic [29:0] a, input logic [31:0] d);
    watch_we = 1'b1; watch_sel = s; watch_en_in = en; watch_addr_in = a; watch_data_in = d;
    cycle();
    watch_we = 1'b0;
  endtask

  initial begin
    rd_by_addr = 1'b1;
    rd_fixed = '0;
    #1;
    do_reset();

    // Four back-to-back reads, read data = byte address + 0xA0.
    rsp_log.delete();
    data_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_addr = 33'h10 + 33'(4 * i); req_wstrb = 4'h0;
      drive_rd();
      cycle();
    end
    req_valid = 1'b0;
    drain(10);
    chk("b2b_count", 64'(rsp_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < rsp_log.size(); i++)
      chk("b2b_rdata", 64'(rsp_log[i]), 64'(32'hB0 + 32'(4 * i)));

    // Back-pressure: third request held while the queue is full.
    rsp_log.delete();
    data_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_valid = 1'b1; req_addr = 33'h40 + 33'(4 * k);
      cycle();
    end
    chk("full_ready", 64'(req_ready), 64'd0);
    cycle();
    data_ready = 1'b1;
    wait_push(10);
    drain(10);
    chk("bp_count", 64'(rsp_log.size()), 64'd3);
    for (int i = 0; i < 3 && i < rsp_log.size(); i++)
      chk("bp_rdata", 64'(rsp_log[i]), 64'(32'hE0 + 32'(4 * i)));

    // Control-space read.
    rsp_log.delete();
    ctrl_ready = 1'b0;
    req_valid = 1'b1; req_addr = {1'b1, 32'h100}; req_wstrb = 4'h0;
    cycle();
    req_valid = 1'b0;
    chk("ctrl_sel_cv", 64'(ctrl_valid), 64'd1);
    chk("ctrl_sel_dv", 64'(data_valid), 64'd0);
    cycle();
    ctrl_ready = 1'b1; ctrl_rdata = 32'h5;
    cycle();
    chk("ctrl_rsp", 64'(rsp_log.size() > 0 ? rsp_log[rsp_log.size() - 1] : 32'hFFFF_FFFF), 64'h5);

    // Watchpoints.
    wprog(2'd0, 1'b1, 30'h1234, 32'hDEADBEEF);
    wprog(2'd1, 1'b0, 30'h1235, 32'hDEADBEEF);
    send({1'b0, 32'h48D0}, 4'h0, 32'hDEADBEEF);
    chk("wp_hit", 64'(watch_hit), 64'h1);
    chk("wp_cnt", 64'(watch_cnt), 64'd1);
    cycle();
    send({1'b0, 32'h48D0}, 4'h0, 32'hDEADBEEE);
    chk("wp_nodata", 64'(watch_hit), 64'h0);
    send({1'b0, 32'h48D0}, 4'hF, 32'hDEADBEEF);
    chk("wp_nowrite", 64'(watch_hit), 64'h0);
    send({1'b0, 32'h48D4}, 4'h0, 32'hDEADBEEF);
    chk("wp_disabled", 64'(watch_hit), 64'h0);
    chk("wp_cnt2", 64'(watch_cnt), 64'd1);

    // Randomized traffic against the model.
    for (int c = 0; c < 500; c++) begin
      req_valid  = 1'($urandom_range(0, 1));
      req_addr   = {1'($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 1) != 0) ? 30'h1234 : 30'h1235,
                    2'($urandom_range(0, 3))};
      req_wstrb  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      req_wdata  = 32'($urandom);
      data_rdata = ($urandom_range(0, 1) != 0) ? 32'hDEADBEEF : 32'($urandom);
      data_ready = 1'($urandom_range(0, 1));
      ctrl_ready = 1'($urandom_range(0, 1));
      ctrl_rdata = 32'($urandom);
      watch_we   = ($urandom_range(0, 9) == 0);
      watch_sel  = 2'($urandom_range(0, 3));
      watch_en_in   = 1'($urandom_range(0, 1));
      watch_addr_in = ($urandom_range(0, 1) != 0) ? 30'h1234 : 30'h1235;
      watch_data_in = ($urandom_range(0, 3) != 0) ? 32'hDEADBEEF : 32'($urandom);
      cycle();
    end
    req_valid = 1'b0;
    watch_we = 1'b0;
    rd_by_addr = 1'b0; rd_fixed = 32'h0;
    data_ready = 1'b1; ctrl_ready = 1'b1;
    drain(10);
    cycle();

    // Saturation of the hit counter.
    wprog(2'd0, 1'b1, 30'h1234, 32'hDEADBEEF);
    for (int i = 0; i < 300; i++) send({1'b0, 32'h48D0}, 4'h0, 32'hDEADBEEF);
    chk("wp_saturate", 64'(watch_cnt), 64'd255);

    // Reset with two queued requests.
    data_ready = 1'b0;
    rd_by_addr = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req_valid = 1'b1; req_addr = 33'h80 + 33'(4 * k); req_wstrb = 4'h0;
      cycle();
    end
    req_valid = 1'b0;
    chk("pre_reset_full", 64'(req_ready), 64'd0);
    data_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 3; i++) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
